// File: rtl/fifo16k_pkg.sv
// Shared definitions for the FIFO_16K_BLK pop-side reader.
// Holds the POP_FLAG encoding, the reader FSM state type and the read-latency helper.
// No logic of its own.
package fifo16k_pkg;

  // POP_FLAG values that carry an exact word count; every other code means two or more.
  localparam logic [3:0] FLAG_EMPTY = 4'h0;
  localparam logic [3:0] FLAG_ONE   = 4'h1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // A registered read port in the FIFO adds one cycle between POP and DOUT.
  function automatic int rd_lat_from_reg_rd(input logic reg_rd_int);
    return reg_rd_int ? 2 : 1;
  endfunction

endpackage

// File: rtl/fifo16k_out_buf.sv
// Circular first-word-fall-through buffer with modulo-DEPTH pointers and a separate count.
// Latency: a word written in cycle t is visible on rd_dat in cycle t+1.
// Backpressure: rd_dat holds while rd_vld && !rd_rdy; writer must never write while full.
//
// Ports: clk, rst_n (async active-low), clr (sync empty), wr_vld/wr_dat (write),
//        rd_vld/rd_dat/rd_rdy (head word and accept), count (current occupancy).
module fifo16k_out_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              rd_rdy,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_rd;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_vld = (count != '0);
  assign do_rd  = rd_vld && rd_rdy;
  // Zero when empty so the output bus is quiet out of reset and after a clear.
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd)  rd_ptr <= ptr_next(rd_ptr);
      // Simultaneous write and accept leave the count unchanged.
      case ({wr_vld, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld && !clr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/fifo16k_pop_reader.sv
// Turns the FIFO_16K_BLK POP/POP_FLAG/DOUT port into a valid/ready stream and sequences pop-side flush.
// Latency: POP to M_Valid is RD_LAT+1 cycles; one word per cycle sustained when the flag shows 2+.
// Backpressure: POP is withheld unless buffered plus in-flight words fit, so M_Ready=0 never drops data.
//
// Ports: Pop_Clk, Pop_Rst_n (async active-low); POP_FLAG/DOUT in and POP/Fifo_Pop_Flush out to the FIFO;
//        Flush_Req (one-cycle request); M_Valid/M_Data/M_Ready stream out; Busy (flush or pop in flight).
module fifo16k_pop_reader
  import fifo16k_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic              Pop_Clk,
  input  logic              Pop_Rst_n,
  input  logic [3:0]        POP_FLAG,
  input  logic [DATA_W-1:0] DOUT,
  output logic              POP,
  output logic              Fifo_Pop_Flush,
  input  logic              Flush_Req,
  output logic              M_Valid,
  output logic [DATA_W-1:0] M_Data,
  input  logic              M_Ready,
  output logic              Busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int DR_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if (RD_LAT < 1) begin : g_bad_lat
    $error("fifo16k_pop_reader: RD_LAT must be at least 1");
  end
  if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("fifo16k_pop_reader: BUF_DEPTH must be at least RD_LAT+1");
  end

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [RD_LAT-1:0] pop_pipe;   // bit i set: POP issued i+1 cycles ago
  logic [DR_W-1:0]   drain_cnt;
  logic [SUM_W-1:0]  inflight;
  logic [CNT_W-1:0]  buf_count;
  logic [1:0]        avail;
  logic              have_word;
  logic              room;
  logic              buf_wr;
  logic              buf_clr;

  always_comb begin
    case (POP_FLAG)
      FLAG_EMPTY: avail = 2'd0;
      FLAG_ONE:   avail = 2'd1;
      default:    avail = 2'd2;
    endcase
  end

  // The flag has not yet seen last cycle's POP, so discount it (saturating at zero).
  assign have_word = (avail > {1'b0, pop_pipe[0]});

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + SUM_W'(pop_pipe[i]);
  end

  // Every word we pop must already have a reserved buffer slot.
  assign room = (SUM_W'(buf_count) + inflight) < SUM_W'(BUF_DEPTH);

  always_comb begin
    state_nxt      = state;
    POP            = 1'b0;
    Fifo_Pop_Flush = 1'b0;
    buf_clr        = 1'b0;
    case (state)
      IDLE: begin
        // A flush request pre-empts a pop in the same cycle; POP is held low in reset.
        if (Flush_Req) state_nxt = FLUSH;
        else           POP = Pop_Rst_n && have_word && room;
      end
      FLUSH: begin
        Fifo_Pop_Flush = 1'b1;
        buf_clr        = 1'b1;
        state_nxt      = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DR_W'(RD_LAT - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Pop_Clk or negedge Pop_Rst_n) begin
    if (!Pop_Rst_n) begin
      state     <= IDLE;
      pop_pipe  <= '0;
      drain_cnt <= '0;
    end else begin
      state       <= state_nxt;
      pop_pipe[0] <= POP;
      for (int i = 1; i < RD_LAT; i++) pop_pipe[i] <= pop_pipe[i-1];
      if (state == DRAIN) drain_cnt <= drain_cnt + DR_W'(1);
      else                drain_cnt <= '0;
    end
  end

  // Words returning during FLUSH/DRAIN belong to the flushed stream and are dropped.
  assign buf_wr = pop_pipe[RD_LAT-1] && (state == IDLE);
  assign Busy   = (state != IDLE) || (pop_pipe != '0);

  fifo16k_out_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk    (Pop_Clk),
    .rst_n  (Pop_Rst_n),
    .clr    (buf_clr),
    .wr_vld (buf_wr),
    .wr_dat (DOUT),
    .rd_vld (M_Valid),
    .rd_dat (M_Data),
    .rd_rdy (M_Ready),
    .count  (buf_count)
  );

endmodule

// File: tb/tb_fifo16k_pop_reader.sv
// Bench for fifo16k_pop_reader: two instances (RD_LAT=1/depth 3, RD_LAT=2/depth 4) share
// flush and ready stimulus; each sees its own emulated FIFO and reference model.
module tb_fifo16k_pop_reader;
  import fifo16k_pkg::*;

  localparam int DW    = 32;
  localparam int NI    = 2;
  localparam int LAT0  = rd_lat_from_reg_rd(1'b0);
  localparam int LAT1  = rd_lat_from_reg_rd(1'b1);
  localparam int DEP0  = 3;
  localparam int DEP1  = 4;
  localparam int SRC_N = 8192;

  logic          Pop_Clk   = 1'b0;
  logic          Pop_Rst_n = 1'b0;
  logic          Flush_Req = 1'b0;
  logic          M_Ready   = 1'b0;
  logic [3:0]    flag [NI];
  logic [DW-1:0] dout [NI];
  logic          pop  [NI];
  logic          fpf  [NI];
  logic          mv   [NI];
  logic [DW-1:0] md   [NI];
  logic          busy [NI];

  always #5 Pop_Clk = ~Pop_Clk;

  fifo16k_pop_reader #(.DATA_W(DW), .RD_LAT(LAT0), .BUF_DEPTH(DEP0)) u_dut0 (
    .Pop_Clk(Pop_Clk), .Pop_Rst_n(Pop_Rst_n), .POP_FLAG(flag[0]), .DOUT(dout[0]),
    .POP(pop[0]), .Fifo_Pop_Flush(fpf[0]), .Flush_Req(Flush_Req),
    .M_Valid(mv[0]), .M_Data(md[0]), .M_Ready(M_Ready), .Busy(busy[0]));

  fifo16k_pop_reader #(.DATA_W(DW), .RD_LAT(LAT1), .BUF_DEPTH(DEP1)) u_dut1 (
    .Pop_Clk(Pop_Clk), .Pop_Rst_n(Pop_Rst_n), .POP_FLAG(flag[1]), .DOUT(dout[1]),
    .POP(pop[1]), .Fifo_Pop_Flush(fpf[1]), .Flush_Req(Flush_Req),
    .M_Valid(mv[1]), .M_Data(md[1]), .M_Ready(M_Ready), .Busy(busy[1]));

  // Reference state: source FIFO contents, words popped but not yet returned, and the
  // words the reader should be presenting downstream.
  logic [DW-1:0] src_mem  [NI][SRC_N];
  int            src_hd   [NI];
  int            src_tl   [NI];
  logic [DW-1:0] ret_word [NI][4];
  int            ret_due  [NI][4];
  int            ret_hd   [NI];
  int            ret_tl   [NI];
  logic [DW-1:0] ob_mem   [NI][8];
  int            ob_hd    [NI];
  int            ob_tl    [NI];
  int            ph_left  [NI];  // non-IDLE cycles still to come, counting the current one
  bit            pop_prev [NI];

  int cyc;
  int n_chk;
  int n_fail;

  bit            o_pop  [NI];
  bit            o_mv   [NI];
  bit            o_busy [NI];
  bit            o_fl   [NI];
  logic [DW-1:0] o_md   [NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? DEP0 : DEP1;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      ret_hd[k]   = ret_tl[k];
      ob_hd[k]    = ob_tl[k];
      ph_left[k]  = 0;
      pop_prev[k] = 1'b0;
    end
  endtask

  task automatic src_push(input int k, input logic [DW-1:0] w);
    src_mem[k][src_tl[k] % SRC_N] = w;
    src_tl[k]++;
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs 1ns later,
  // then advance the reference model across the rising edge.
  task automatic step(input bit in_rst, input bit fr, input bit rdy, input int push_pct);
    bit            e_pop  [NI];
    bit            e_mv   [NI];
    bit            e_fl   [NI];
    bit            e_busy [NI];
    bit            cap    [NI];
    logic [DW-1:0] e_md   [NI];
    int            inflt  [NI];
    int            bc     [NI];
    @(negedge Pop_Clk);
    Pop_Rst_n = !in_rst;
    Flush_Req = in_rst ? 1'b0 : fr;
    M_Ready   = rdy;
    for (int k = 0; k < NI; k++) begin
      int  lvl, av, ave, occ;
      bit  idle;
      if ($urandom_range(99) < push_pct) src_push(k, $urandom);
      // Flag reflects every pop except the one issued last cycle.
      lvl = src_tl[k] - src_hd[k] + int'(pop_prev[k]);
      if (in_rst)        flag[k] = 4'h5;
      else if (lvl == 0) flag[k] = 4'h0;
      else if (lvl == 1) flag[k] = 4'h1;
      else               flag[k] = 4'($urandom_range(15, 2));
      av       = (lvl > 2) ? 2 : lvl;
      ave      = av - int'(pop_prev[k]);
      if (ave < 0) ave = 0;
      inflt[k] = ret_tl[k] - ret_hd[k];
      occ      = ob_tl[k] - ob_hd[k];
      idle     = (ph_left[k] == 0);
      cap[k]   = !in_rst && inflt[k] > 0 && ret_due[k][ret_hd[k] % 4] == cyc;
      dout[k]  = cap[k] ? ret_word[k][ret_hd[k] % 4] : $urandom;
      e_pop[k]  = !in_rst && idle && !fr && ave >= 1 && (occ + inflt[k]) < dep_of(k);
      e_mv[k]   = !in_rst && occ > 0;
      e_md[k]   = e_mv[k] ? ob_mem[k][ob_hd[k] % 8] : '0;
      e_fl[k]   = !in_rst && ph_left[k] == 1 + lat_of(k);
      e_busy[k] = !in_rst && (!idle || inflt[k] > 0);
    end
    #1;
    bc[0] = int'(u_dut0.u_buf.count);
    bc[1] = int'(u_dut1.u_buf.count);
    for (int k = 0; k < NI; k++) begin
      o_pop[k] = pop[k]; o_mv[k] = mv[k]; o_busy[k] = busy[k]; o_fl[k] = fpf[k]; o_md[k] = md[k];
      chk($sformatf("pop%0d", k),   pop[k],  e_pop[k]);
      chk($sformatf("valid%0d", k), mv[k],   e_mv[k]);
      chk($sformatf("data%0d", k),  md[k],   e_md[k]);
      chk($sformatf("flush%0d", k), fpf[k],  e_fl[k]);
      chk($sformatf("busy%0d", k),  busy[k], e_busy[k]);
      if (cap[k] && ph_left[k] == 0) chk($sformatf("cap_room%0d", k), bc[k] < dep_of(k), 1'b1);
    end
    @(posedge Pop_Clk);
    if (!in_rst) begin
      for (int k = 0; k < NI; k++) begin
        if (e_mv[k] && rdy) ob_hd[k]++;
        if (cap[k]) begin
          if (ph_left[k] == 0) begin
            ob_mem[k][ob_tl[k] % 8] = ret_word[k][ret_hd[k] % 4];
            ob_tl[k]++;
          end
          ret_hd[k]++;
        end
        if (e_fl[k]) begin
          ob_hd[k]  = ob_tl[k];
          src_hd[k] = src_tl[k];  // the FIFO itself is emptied by the flush strobe
        end
        if (e_pop[k] && src_tl[k] > src_hd[k]) begin
          ret_word[k][ret_tl[k] % 4] = src_mem[k][src_hd[k] % SRC_N];
          ret_due[k][ret_tl[k] % 4]  = cyc + lat_of(k);
          ret_tl[k]++;
          src_hd[k]++;
        end
        if (ph_left[k] == 0 && fr) ph_left[k] = 1 + lat_of(k);
        else if (ph_left[k] > 0)   ph_left[k]--;
        pop_prev[k] = e_pop[k];
      end
    end
    cyc++;
  endtask

  initial begin
    int npop [NI];
    int first_pop [NI];
    int last_pop [NI];
    int first_mv [NI];
    int nfl, nbusy0, nbusy1;

    for (int k = 0; k < NI; k++) begin
      flag[k] = 4'h5; dout[k] = '0;
      for (int i = 0; i < 4; i++) src_push(k, $urandom);
    end
    model_reset();

    // Reset hold, then release: the first cycle out of reset must pop.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("first_pop0", o_pop[0], 1'b1);
    chk("first_pop1", o_pop[1], 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 0);

    // Single word: flag=1 must give exactly one POP.
    for (int k = 0; k < NI; k++) begin src_push(k, 32'hA5A5_0001); npop[k] = 0; end
    for (int s = 0; s < 6; s++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      for (int k = 0; k < NI; k++) npop[k] += int'(o_pop[k]);
      if (s == 1) chk("single_early_valid", o_mv[0], 1'b0);
      if (s == 2) begin
        chk("single_valid", o_mv[0], 1'b1);
        chk("single_data", o_md[0], 32'hA5A5_0001);
      end
    end
    chk("single_npop0", npop[0], 1);
    chk("single_npop1", npop[1], 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 0);

    // Streaming words 0..7 with M_Ready held high.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 8; i++) src_push(k, DW'(i));
      npop[k] = 0; first_pop[k] = -1; last_pop[k] = -1; first_mv[k] = -1;
    end
    for (int s = 0; s < 14; s++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      for (int k = 0; k < NI; k++) begin
        if (o_pop[k]) begin
          npop[k]++;
          if (first_pop[k] < 0) first_pop[k] = s;
          last_pop[k] = s;
        end
        if (o_mv[k] && first_mv[k] < 0) first_mv[k] = s;
      end
    end
    chk("stream_npop1", npop[1], 8);
    chk("stream_span1", last_pop[1] - first_pop[1], 7);
    chk("stream_lat1", first_mv[1] - first_pop[1], LAT1 + 1);
    chk("stream_lat0", first_mv[0] - first_pop[0], LAT0 + 1);

    // Backpressure: exactly BUF_DEPTH pops with M_Ready low.
    for (int k = 0; k < NI; k++) npop[k] = 0;
    for (int s = 0; s < 12; s++) begin
      step(1'b0, 1'b0, 1'b0, 100);
      for (int k = 0; k < NI; k++) npop[k] += int'(o_pop[k]);
    end
    chk("bp_npop0", npop[0], DEP0);
    chk("bp_npop1", npop[1], DEP1);

    // Flush with 3 buffered and one in flight.
    step(1'b0, 1'b0, 1'b1, 100);
    step(1'b0, 1'b0, 1'b0, 100);
    chk("pre_flush_pop1", o_pop[1], 1'b1);
    nfl = 0; nbusy0 = 0; nbusy1 = 0;
    for (int s = 0; s < 7; s++) begin
      step(1'b0, s == 0, 1'b0, 0);
      nfl    += int'(o_fl[1]);
      nbusy0 += int'(o_busy[0]);
      nbusy1 += int'(o_busy[1]);
    end
    chk("flush_pulses", nfl, 1);
    chk("flush_busy0", nbusy0, 2 + LAT0);
    chk("flush_busy1", nbusy1, 2 + LAT1);
    npop[1] = 0;
    for (int s = 0; s < 10; s++) begin
      step(1'b0, 1'b0, $urandom_range(1), 100);
      npop[1] += int'(o_pop[1]);
    end
    chk("flush_resume", npop[1] > 0, 1'b1);

    // Asynchronous reset between edges while words are buffered.
    for (int s = 0; s < 6; s++) step(1'b0, 1'b0, 1'b0, 100);
    #2;
    chk("pre_rst_valid0", mv[0], 1'b1);
    chk("pre_rst_valid1", mv[1], 1'b1);
    Pop_Rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("arst_valid%0d", k), mv[k], 1'b0);
      chk($sformatf("arst_pop%0d", k), pop[k], 1'b0);
      chk($sformatf("arst_data%0d", k), md[k], '0);
    end
    model_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 0);

    // Randomised traffic with occasional flushes and varying source fill rate.
    begin
      int pct;
      pct = 50;
      for (int s = 0; s < 2000; s++) begin
        if (s % 200 == 0) pct = $urandom_range(100);
        step(1'b0, $urandom_range(99) < 2, $urandom_range(99) < 70, pct);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
